// File: rtl/arb2_burst_xfer_pkg.sv
// Shared types and constants for the arb2 burst transfer stage.
package arb2_burst_xfer_pkg;

    // Channel ownership state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN1 = 2'd1,
        OWN2 = 2'd2
    } state_t;

    // Encoding of out_src.
    localparam logic SRC_P1 = 1'b0;
    localparam logic SRC_P2 = 1'b1;

    // Width of the per-ownership beat counter. It holds 0..max_burst-1.
    function automatic int cnt_width(input int max_burst);
        return (max_burst > 2) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/arb2_burst_fifo.sv
// Small synchronous FIFO with a combinational head. A full FIFO refuses a
// push even when it pops in the same cycle, which keeps o_full purely
// registered-state based.
module arb2_burst_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rptr[AW-1:0]];

    // Pointer update; reset flushes the FIFO by equalising the pointers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage write.
    // NOTE: the array has no reset; entries are only read after being
    // written, so clearing them would cost flops for no behavioural gain.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/arb2_burst_xfer.sv
// Transfer stage around a two-requester arbiter: buffers beats per port and
// locks the shared output channel to the granted port until its burst ends
// (last beat or MAX_BURST beats, whichever comes first).
module arb2_burst_xfer
    import arb2_burst_xfer_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    input  logic              in2_valid,
    output logic              in2_ready,
    input  logic [DATA_W-1:0] in2_data,
    input  logic              in2_last,
    output logic              req1,
    output logic              req2,
    input  logic              gnt1,
    input  logic              gnt2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_src,
    output logic              burst_err,
    output logic              busy
);

    localparam int CNT_W = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             r_burst_err;

    logic             w_full1, w_empty1, w_full2, w_empty2;
    logic [DATA_W:0]  w_head1, w_head2;
    logic             w_own1, w_own2, w_idle;
    logic             w_pop, w_pop1, w_pop2;
    logic             w_out_valid;
    logic [DATA_W:0]  w_head;

    assign w_idle = (r_state == IDLE);
    assign w_own1 = (r_state == OWN1);
    assign w_own2 = (r_state == OWN2);

    arb2_burst_fifo #(.WIDTH(DATA_W + 1), .DEPTH(DEPTH)) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in1_valid),
        .i_data  ({in1_last, in1_data}),
        .i_pop   (w_pop1),
        .o_head  (w_head1),
        .o_full  (w_full1),
        .o_empty (w_empty1)
    );

    arb2_burst_fifo #(.WIDTH(DATA_W + 1), .DEPTH(DEPTH)) u_fifo2 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in2_valid),
        .i_data  ({in2_last, in2_data}),
        .i_pop   (w_pop2),
        .o_head  (w_head2),
        .o_full  (w_full2),
        .o_empty (w_empty2)
    );

    assign in1_ready = ~w_full1;
    assign in2_ready = ~w_full2;

    // The non-owner is masked so the arbiter can only ever grant the owner.
    assign req1 = ~w_empty1 & (w_idle | w_own1);
    assign req2 = ~w_empty2 & (w_idle | w_own2);

    // Output channel mux: present the owner's FIFO head, zeroed when idle.
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        w_out_valid = 1'b0;
        w_head      = '0;
        if (w_own1) begin
            w_out_valid = ~w_empty1;
            w_head      = w_head1;
        end else if (w_own2) begin
            w_out_valid = ~w_empty2;
            w_head      = w_head2;
        end
        if (!w_out_valid) w_head = '0;
    end

    assign w_pop  = w_out_valid & out_ready;
    assign w_pop1 = w_pop & w_own1;
    assign w_pop2 = w_pop & w_own2;

    assign out_valid = w_out_valid;
    assign out_data  = w_head[DATA_W-1:0];
    assign out_last  = w_head[DATA_W];
    assign out_src   = w_own2 ? SRC_P2 : SRC_P1;
    assign burst_err = r_burst_err;
    assign busy      = ~w_idle;

    // Ownership FSM with beat counting and forced-termination pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_beat_cnt  <= '0;
            r_burst_err <= 1'b0;
        end else begin
            r_burst_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (gnt1)      r_state <= OWN1;
                    else if (gnt2) r_state <= OWN2;
                end
                OWN1, OWN2: begin
                    if (w_pop) begin
                        if (w_head[DATA_W]) begin
                            r_state    <= IDLE;
                            r_beat_cnt <= '0;
                        end else if (r_beat_cnt == CNT_LAST) begin
                            // Remaining beats will compete again as a new burst.
                            r_state     <= IDLE;
                            r_beat_cnt  <= '0;
                            r_burst_err <= 1'b1;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb2_burst_xfer.sv
// Directed bench for arb2_burst_xfer. A small round-robin arbiter model closes
// the req/gnt loop. Observations are packed as
// {3'b0, out_valid, out_last, out_src, busy, burst_err, out_data[7:0]}.
module tb_arb2_burst_xfer;

    logic       clk;
    logic       rst;
    logic       in1_valid, in1_ready, in1_last;
    logic [7:0] in1_data;
    logic       in2_valid, in2_ready, in2_last;
    logic [7:0] in2_data;
    logic       req1, req2, gnt1, gnt2;
    logic       out_valid, out_ready, out_last, out_src, burst_err, busy;
    logic [7:0] out_data;

    int total;
    int bad;

    arb2_burst_xfer #(.DATA_W(8), .DEPTH(4), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in2_valid (in2_valid),
        .in2_ready (in2_ready),
        .in2_data  (in2_data),
        .in2_last  (in2_last),
        .req1      (req1),
        .req2      (req2),
        .gnt1      (gnt1),
        .gnt2      (gnt2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .burst_err (burst_err),
        .busy      (busy)
    );

    // Arbiter model: round robin, port 1 preferred after reset.
    logic r_prio;
    always_comb begin
        gnt1 = req1 & (~req2 | ~r_prio);
        gnt2 = req2 & (~req1 | r_prio);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_prio <= 1'b0;
        else if (gnt1) r_prio <= 1'b1;
        else if (gnt2) r_prio <= 1'b0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Illegal simultaneous grants.
    always @(negedge clk) begin
        if (!rst && gnt1 && gnt2) begin
            total++;
            bad++;
            $display("FAIL dual_grant: got gnt1=%b gnt2=%b want at most one", gnt1, gnt2);
        end
    end

    function automatic logic [15:0] snap();
        return {3'b000, out_valid, out_last, out_src, busy, burst_err, out_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in1_valid = 0; in1_data = 0; in1_last = 0;
        in2_valid = 0; in2_data = 0; in2_last = 0;
        out_ready = 0;
        #12;
        total++;
        if (snap() !== 16'h0000) begin
            bad++;
            $display("FAIL reset_outs: got %h want %h", snap(), 16'h0000);
        end
        total++;
        if ({req1, req2, in1_ready, in2_ready} !== 4'b0011) begin
            bad++;
            $display("FAIL reset_handshake: got %b want %b", {req1, req2, in1_ready, in2_ready}, 4'b0011);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (snap() !== 16'h0000 || {req1, req2} !== 2'b00) begin
            bad++;
            $display("FAIL post_reset_idle: got %h req=%b want 0000 req=00", snap(), {req1, req2});
        end
    endtask

    task automatic test_both_ports();
        logic [15:0] exp [7] = '{16'h0000, 16'h12B0, 16'h1AB1, 16'h0000,
                                 16'h16C0, 16'h1EC1, 16'h0000};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in1_valid = (i < 2); in1_data = 8'hB0 + 8'(i); in1_last = (i == 1);
            in2_valid = (i < 2); in2_data = 8'hC0 + 8'(i); in2_last = (i == 1);
            tick();
            @(negedge clk);
            if (i == 0) begin
                total++;
                if ({req1, req2} !== 2'b11) begin
                    bad++;
                    $display("FAIL both_req: got %b want 11", {req1, req2});
                end
            end
            total++;
            if (snap() !== exp[i]) begin
                bad++;
                $display("FAIL both_ports step %0d: got %h want %h", i, snap(), exp[i]);
            end
        end
    endtask

    task automatic test_single_burst();
        logic [15:0] exp [5] = '{16'h0000, 16'h12A0, 16'h12A1, 16'h1AA2, 16'h0000};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in1_valid = (i < 3); in1_data = 8'hA0 + 8'(i); in1_last = (i == 2);
            in2_valid = 1'b0;
            tick();
            @(negedge clk);
            if (i == 0) begin
                total++;
                if (req1 !== 1'b1) begin
                    bad++;
                    $display("FAIL single_req1: got %b want 1", req1);
                end
            end
            total++;
            if (snap() !== exp[i]) begin
                bad++;
                $display("FAIL single_burst step %0d: got %h want %h", i, snap(), exp[i]);
            end
        end
    endtask

    task automatic test_ready_toggle();
        logic [15:0] exp [8] = '{16'h0000, 16'h16D0, 16'h16D0, 16'h16D1,
                                 16'h16D1, 16'h16D1, 16'h1ED2, 16'h0000};
        logic        rdy [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        in1_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in2_valid = (i < 3); in2_data = 8'hD0 + 8'(i); in2_last = (i == 2);
            out_ready = rdy[i];
            tick();
            @(negedge clk);
            total++;
            if (snap() !== exp[i]) begin
                bad++;
                $display("FAIL ready_toggle step %0d: got %h want %h", i, snap(), exp[i]);
            end
        end
    endtask

    task automatic test_max_burst();
        logic [15:0] exp [9] = '{16'h0000, 16'h12E0, 16'h12E1, 16'h12E2, 16'h12E3,
                                 16'h0100, 16'h12E4, 16'h1AE5, 16'h0000};
        out_ready = 1'b1;
        in2_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in1_valid = (i < 6); in1_data = 8'hE0 + 8'(i); in1_last = (i == 5);
            tick();
            @(negedge clk);
            total++;
            if (snap() !== exp[i]) begin
                bad++;
                $display("FAIL max_burst step %0d: got %h want %h", i, snap(), exp[i]);
            end
        end
    endtask

    task automatic test_fifo_full();
        logic [15:0] exp [9] = '{16'h0000, 16'h12F0, 16'h12F0, 16'h12F0, 16'h12F0,
                                 16'h12F1, 16'h12F2, 16'h1AF3, 16'h0000};
        logic        rdy_exp [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        ordy [9]    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        in2_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in1_valid = (i < 6); in1_data = 8'hF0 + 8'(i); in1_last = (i == 3);
            out_ready = ordy[i];
            tick();
            @(negedge clk);
            total++;
            if (in1_ready !== rdy_exp[i]) begin
                bad++;
                $display("FAIL fifo_full_ready step %0d: got %b want %b", i, in1_ready, rdy_exp[i]);
            end
            total++;
            if (snap() !== exp[i]) begin
                bad++;
                $display("FAIL fifo_full_data step %0d: got %h want %h", i, snap(), exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] exp [4] = '{16'h0000, 16'h1270, 16'h1A71, 16'h0000};
        out_ready = 1'b1;
        in2_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in1_valid = 1'b1; in1_data = 8'h50 + 8'(i); in1_last = (i == 2);
            tick();
        end
        in1_valid = 1'b0;
        @(negedge clk);
        total++;
        if (snap() !== 16'h1251) begin
            bad++;
            $display("FAIL mid_burst_beat2: got %h want %h", snap(), 16'h1251);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, busy, req1, in1_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_mid_burst: got %b want 0001", {out_valid, busy, req1, in1_ready});
        end
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (snap() !== 16'h0000 || {req1, req2} !== 2'b00) begin
            bad++;
            $display("FAIL after_reset_empty: got %h req=%b want 0000 req=00", snap(), {req1, req2});
        end
        for (int i = 0; i < 4; i++) begin
            in1_valid = (i < 2); in1_data = 8'h70 + 8'(i); in1_last = (i == 1);
            tick();
            @(negedge clk);
            total++;
            if (snap() !== exp[i]) begin
                bad++;
                $display("FAIL restart step %0d: got %h want %h", i, snap(), exp[i]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_both_ports();
        test_single_burst();
        test_ready_toggle();
        test_max_burst();
        test_fifo_full();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
